rtc_read_sequencer: RTL and testbench

Transaction sequencer that sits directly upstream of the bus-multiplexed RTC protocol stage and also consumes its captured read byte. It sweeps the six RTC time registers in read mode, and drives the register address and the read/write mode flag for each transaction. It also inserts user write requests between reads. Captured bytes go into a BCD shadow set, which is published as a coherent time snapshot to the VGA display path.

---
 rtl/rtc_read_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_read_sequencer.sv
// ---------------------------------------------------------------------------
// rtc_read_sequencer
//
// Transaction sequencer for the bus-multiplexed RTC protocol stage. It sweeps
// the six RTC time registers (seconds .. year) in read mode and captures each
// returned byte into a BCD shadow set. After the year register it publishes
// the whole shadow set at once, so the VGA path always sees a coherent time.
// A single user write request can be latched at any time. It is inserted
// before the next read window, and the interrupted sweep resumes afterwards.
//
// Ports
//   clk_i                 system clock (100 MHz)
//   reset_i               asynchronous, active-high reset
//   rd_data_i   [7:0]     byte captured by the protocol stage
//   refresh_en_i          level, allows new read windows to start
//   wr_req_i              one-cycle write request
//   wr_addr_i   [7:0]     write target address, sampled with wr_req_i
//   wr_data_i   [7:0]     write value (BCD), sampled with wr_req_i
//   address_o   [7:0]     RTC register address of the current transaction
//   data_write_o[7:0]     write byte of the current transaction
//   indicador_maquina_o   1 = read transaction, 0 = write transaction
//   busy_o                high while a transaction window is open
//   wr_ack_o              one-cycle pulse when a write transaction completes
//   update_o              one-cycle pulse when a new snapshot is published
//   bcd_err_o             one-cycle pulse when a captured byte is not BCD
//   seg_o .. anio_o [7:0] published BCD time fields
// ---------------------------------------------------------------------------
module rtc_read_sequencer #(
    parameter int unsigned TXN_CYCLES = 230,
    parameter logic [7:0]  BASE_ADDR  = 8'h21
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rd_data_i,
    input  logic       refresh_en_i,
    input  logic       wr_req_i,
    input  logic [7:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    output logic [7:0] address_o,
    output logic [7:0] data_write_o,
    output logic       indicador_maquina_o,
    output logic       busy_o,
    output logic       wr_ack_o,
    output logic       update_o,
    output logic       bcd_err_o,
    output logic [7:0] seg_o,
    output logic [7:0] min_o,
    output logic [7:0] hora_o,
    output logic [7:0] dia_o,
    output logic [7:0] mes_o,
    output logic [7:0] anio_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_WDONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TXN_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'd5;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            wr_pend_q, wr_pend_d;
    logic [7:0]      wa_q, wa_d;
    logic [7:0]      wd_q, wd_d;
    logic [5:0][7:0] sh_q, sh_d;     // shadow fields, [0] = seconds
    logic [5:0][7:0] pub_q, pub_d;   // published snapshot

    logic [7:0]      address_q, address_d;
    logic [7:0]      data_write_q, data_write_d;
    logic            ind_q, ind_d;
    logic            busy_q, busy_d;
    logic            wr_ack_q, wr_ack_d;
    logic            update_q, update_d;
    logic            bcd_err_q, bcd_err_d;

    logic            rd_is_bcd;
    logic [7:0]      wa_off;
    logic            wa_hit;

    assign rd_is_bcd = (rd_data_i[7:4] <= 4'd9) && (rd_data_i[3:0] <= 4'd9);

    // Offset form avoids wrap-around when BASE_ADDR+5 would overflow 8 bits.
    assign wa_off = wa_q - BASE_ADDR;
    assign wa_hit = (wa_q >= BASE_ADDR) && (wa_off < 8'd6);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wr_pend_d    = wr_pend_q;
        wa_d         = wa_q;
        wd_d         = wd_q;
        sh_d         = sh_q;
        pub_d        = pub_q;
        address_d    = address_q;
        data_write_d = data_write_q;
        ind_d        = ind_q;
        busy_d       = 1'b0;
        wr_ack_d     = 1'b0;
        update_d     = 1'b0;
        bcd_err_d    = 1'b0;

        // Only one write can be pending; extra requests are dropped silently.
        if (wr_req_i && !wr_pend_q) begin
            wr_pend_d = 1'b1;
            wa_d      = wr_addr_i;
            wd_d      = wr_data_i;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_pend_q) begin
                    state_d      = S_WRITE;
                    cnt_d        = 8'd0;
                    address_d    = wa_q;
                    data_write_d = wd_q;
                    ind_d        = 1'b0;
                    busy_d       = 1'b1;
                end else if (refresh_en_i) begin
                    state_d   = S_READ;
                    cnt_d     = 8'd0;
                    address_d = BASE_ADDR + {5'd0, idx_q};
                    ind_d     = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    busy_d = 1'b1;
                end
            end

            S_CAPTURE: begin
                if (rd_is_bcd) begin
                    sh_d[idx_q] = rd_data_i;
                end else begin
                    bcd_err_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d    = 3'd0;
                    pub_d    = sh_d;   // includes the byte accepted this cycle
                    update_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
                state_d = S_IDLE;
            end

            S_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WDONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    busy_d = 1'b1;
                end
            end

            S_WDONE: begin
                wr_ack_d = 1'b1;
                // A request arriving now replaces the one being retired.
                if (wr_req_i) begin
                    wr_pend_d = 1'b1;
                    wa_d      = wr_addr_i;
                    wd_d      = wr_data_i;
                end else begin
                    wr_pend_d = 1'b0;
                end
                // Keep the shadow consistent with what was just written to
                // the RTC; published fields change only at the next update.
                if (wa_hit) begin
                    sh_d[wa_off[2:0]] = wd_q;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            idx_q        <= 3'd0;
            wr_pend_q    <= 1'b0;
            wa_q         <= 8'd0;
            wd_q         <= 8'd0;
            sh_q         <= '0;
            pub_q        <= '0;
            address_q    <= 8'h00;
            data_write_q <= 8'h00;
            ind_q        <= 1'b1;
            busy_q       <= 1'b0;
            wr_ack_q     <= 1'b0;
            update_q     <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wr_pend_q    <= wr_pend_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            sh_q         <= sh_d;
            pub_q        <= pub_d;
            address_q    <= address_d;
            data_write_q <= data_write_d;
            ind_q        <= ind_d;
            busy_q       <= busy_d;
            wr_ack_q     <= wr_ack_d;
            update_q     <= update_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign address_o           = address_q;
    assign data_write_o        = data_write_q;
    assign indicador_maquina_o = ind_q;
    assign busy_o              = busy_q;
    assign wr_ack_o            = wr_ack_q;
    assign update_o            = update_q;
    assign bcd_err_o           = bcd_err_q;
    assign seg_o               = pub_q[0];
    assign min_o               = pub_q[1];
    assign hora_o              = pub_q[2];
    assign dia_o               = pub_q[3];
    assign mes_o               = pub_q[4];
    assign anio_o              = pub_q[5];

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for rtc_read_sequencer. The RTC is modelled by a small
// register array answering rd_data from the current address. Expected
// snapshots and write acknowledgements are queued when stimulus is applied
// and popped when the DUT pulses update / wr_ack.
// ---------------------------------------------------------------------------
module tb_rtc_read_sequencer;

    localparam int         TXN  = 230;
    localparam logic [7:0] BASE = 8'h21;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] rd_data_i;
    logic       refresh_en_i;
    logic       wr_req_i;
    logic [7:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic [7:0] address_o;
    logic [7:0] data_write_o;
    logic       indicador_maquina_o;
    logic       busy_o;
    logic       wr_ack_o;
    logic       update_o;
    logic       bcd_err_o;
    logic [7:0] seg_o, min_o, hora_o, dia_o, mes_o, anio_o;

    rtc_read_sequencer #(
        .TXN_CYCLES(TXN),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .rd_data_i          (rd_data_i),
        .refresh_en_i       (refresh_en_i),
        .wr_req_i           (wr_req_i),
        .wr_addr_i          (wr_addr_i),
        .wr_data_i          (wr_data_i),
        .address_o          (address_o),
        .data_write_o       (data_write_o),
        .indicador_maquina_o(indicador_maquina_o),
        .busy_o             (busy_o),
        .wr_ack_o           (wr_ack_o),
        .update_o           (update_o),
        .bcd_err_o          (bcd_err_o),
        .seg_o              (seg_o),
        .min_o              (min_o),
        .hora_o             (hora_o),
        .dia_o              (dia_o),
        .mes_o              (mes_o),
        .anio_o             (anio_o)
    );

    always #5 clk_i = ~clk_i;

    // RTC register model: answers the register currently addressed.
    logic [7:0] mem [6];
    int         rd_off;
    always_comb begin
        rd_off    = int'(address_o) - int'(BASE);
        rd_data_i = 8'h00;
        if (rd_off >= 0 && rd_off < 6) rd_data_i = mem[rd_off];
    end

    logic [5:0][7:0] fields;
    assign fields = {anio_o, mes_o, dia_o, hora_o, min_o, seg_o};

    typedef struct {
        logic [5:0][7:0] rd;
        logic [5:0][7:0] exp;
        int              errs;
    } row_t;

    int checks = 0;
    int errors = 0;

    // scoreboard and monitor state
    logic [5:0][7:0] upd_q [$];
    logic [15:0]     ack_q [$];
    logic [16:0]     win_log [$];   // {indicador, address, data_write}
    logic [5:0][7:0] prev_fields;
    int              sample = 0;
    int              bcd_cnt = 0;
    int              ack_cnt = 0;
    bit              in_win = 0;
    int              win_len;
    logic [7:0]      win_addr, win_data;
    logic            win_ind;
    int              last_wr_fall = -10;
    logic [7:0]      last_wr_addr, last_wr_data;
    string           fname [6] = '{"seg", "min", "hora", "dia", "mes", "anio"};

    function automatic logic [5:0][7:0] pack6(input logic [7:0] s, input logic [7:0] mi,
                                              input logic [7:0] h, input logic [7:0] d,
                                              input logic [7:0] me, input logic [7:0] a);
        logic [5:0][7:0] v;
        v[0] = s; v[1] = mi; v[2] = h; v[3] = d; v[4] = me; v[5] = a;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, detail, $time);
    endtask

    // One clock step followed by the monitor, sampled 1 ns after the edge.
    task automatic tick();
        logic [5:0][7:0] e;
        logic [15:0]     ea;
        @(posedge clk_i);
        #1;
        sample++;
        if (reset_i) begin
            in_win = 0;
        end else begin
            if (!update_o && fields !== prev_fields)
                flag("fields_change_without_update", $sformatf("was %0h now %0h", prev_fields, fields));
            if (update_o) begin
                if (upd_q.size() == 0) begin
                    flag("update_unexpected", $sformatf("fields %0h", fields));
                end else begin
                    e = upd_q.pop_front();
                    for (int i = 0; i < 6; i++) chk({"update_", fname[i]}, 64'(fields[i]), 64'(e[i]));
                    $display("update: snapshot %0h", fields);
                end
            end
            if (bcd_err_o) bcd_cnt++;
            if (busy_o && !in_win) begin
                in_win   = 1;
                win_len  = 1;
                win_addr = address_o;
                win_data = data_write_o;
                win_ind  = indicador_maquina_o;
                win_log.push_back({indicador_maquina_o, address_o, data_write_o});
            end else if (busy_o && in_win) begin
                win_len++;
                if (address_o !== win_addr || indicador_maquina_o !== win_ind ||
                    (!win_ind && data_write_o !== win_data))
                    flag("window_unstable", $sformatf("addr %0h ind %0b", address_o, indicador_maquina_o));
            end else if (!busy_o && in_win) begin
                in_win = 0;
                chk("window_length", 64'(win_len), 64'(TXN));
                $display("window: ind=%0b addr=%0h data=%0h len=%0d", win_ind, win_addr, win_data, win_len);
                if (!win_ind) begin
                    last_wr_fall = sample;
                    last_wr_addr = win_addr;
                    last_wr_data = win_data;
                end
            end
            if (wr_ack_o) begin
                ack_cnt++;
                if (ack_q.size() == 0) begin
                    flag("wr_ack_unexpected", $sformatf("last write %0h/%0h", last_wr_addr, last_wr_data));
                end else begin
                    ea = ack_q.pop_front();
                    chk("wr_ack_addr_data", 64'({last_wr_addr, last_wr_data}), 64'(ea));
                    chk("wr_ack_timing", 64'(sample), 64'(last_wr_fall + 1));
                    $display("wr_ack: addr=%0h data=%0h", last_wr_addr, last_wr_data);
                end
            end
        end
        prev_fields = fields;
    endtask

    task automatic wait_update(input int limit, input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!update_o && n < limit);
        if (!update_o) flag(name, "timeout waiting for update");
    endtask

    task automatic wait_busy(input logic level, input int limit, input string name);
        int n = 0;
        while (busy_o !== level && n < limit) begin
            tick();
            n++;
        end
        if (busy_o !== level) flag(name, $sformatf("timeout waiting for busy=%0b", level));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_address"}, 64'(address_o), 64'h00);
        chk({tag, "_data_write"}, 64'(data_write_o), 64'h00);
        chk({tag, "_indicador"}, 64'(indicador_maquina_o), 64'h1);
        chk({tag, "_busy"}, 64'(busy_o), 64'h0);
        chk({tag, "_wr_ack"}, 64'(wr_ack_o), 64'h0);
        chk({tag, "_update"}, 64'(update_o), 64'h0);
        chk({tag, "_bcd_err"}, 64'(bcd_err_o), 64'h0);
        chk({tag, "_fields"}, 64'(fields), 64'h0);
    endtask

    task automatic set_mem(input logic [5:0][7:0] v);
        for (int i = 0; i < 6; i++) mem[i] = v[i];
    endtask

    row_t rows [4];
    logic [16:0] exp_log [7];
    int n, w0, a0, bc;

    initial begin
        rows[0] = '{pack6(8'h45, 8'h30, 8'h12, 8'h07, 8'h09, 8'h24),
                    pack6(8'h45, 8'h30, 8'h12, 8'h07, 8'h09, 8'h24), 0};
        rows[1] = '{pack6(8'h59, 8'h3A, 8'h23, 8'h31, 8'h12, 8'h99),
                    pack6(8'h59, 8'h30, 8'h23, 8'h31, 8'h12, 8'h99), 1};
        rows[2] = '{pack6(8'h00, 8'h59, 8'hA0, 8'h0F, 8'h10, 8'h00),
                    pack6(8'h00, 8'h59, 8'h23, 8'h31, 8'h10, 8'h00), 2};
        rows[3] = '{pack6(8'h99, 8'h00, 8'hFA, 8'h01, 8'h01, 8'h01),
                    pack6(8'h99, 8'h00, 8'h23, 8'h01, 8'h01, 8'h01), 1};

        reset_i      = 1'b1;
        refresh_en_i = 1'b1;
        wr_req_i     = 1'b0;
        wr_addr_i    = 8'h00;
        wr_data_i    = 8'h00;
        set_mem('0);
        repeat (3) tick();
        check_reset_values("reset");

        // Release reset between edges; the next rising edge is edge 1.
        #2 reset_i = 1'b0;

        // Table: continuous sweeps, one update every 6*(TXN+2) clocks.
        for (int r = 0; r < 4; r++) begin
            set_mem(rows[r].rd);
            upd_q.push_back(rows[r].exp);
            a0 = bcd_cnt;
            wait_update(2000, $sformatf("sweep%0d_update", r), n);
            chk($sformatf("sweep%0d_period", r), 64'(n), 64'(6 * (TXN + 2)));
            chk($sformatf("sweep%0d_bcd_err_count", r), 64'(bcd_cnt - a0), 64'(rows[r].errs));
        end

        // Write request arriving in the middle of the idx 1 read.
        set_mem(pack6(8'h11, 8'h41, 8'h22, 8'h05, 8'h06, 8'h25));
        upd_q.push_back(pack6(8'h11, 8'h41, 8'h22, 8'h05, 8'h06, 8'h25));
        w0 = win_log.size();
        n = 0;
        while (!(busy_o && address_o == 8'h22) && n < 3000) begin
            tick();
            n++;
        end
        chk("reach_read_22h", 64'(n < 3000), 64'h1);
        repeat (50) tick();
        wr_addr_i = 8'h23; wr_data_i = 8'h08; wr_req_i = 1'b1;
        ack_q.push_back(16'h2308);
        tick();
        wr_req_i = 1'b0;
        wait_update(4000, "midread_write_update", n);
        exp_log = '{{1'b1, 8'h21, 8'h00}, {1'b1, 8'h22, 8'h00}, {1'b0, 8'h23, 8'h08},
                    {1'b1, 8'h23, 8'h00}, {1'b1, 8'h24, 8'h00}, {1'b1, 8'h25, 8'h00},
                    {1'b1, 8'h26, 8'h00}};
        chk("midread_window_count", 64'(win_log.size() - w0), 64'd7);
        if (win_log.size() >= w0 + 7) begin
            for (int i = 0; i < 7; i++) begin
                if (exp_log[i][16])
                    chk($sformatf("midread_window%0d", i), 64'(win_log[w0 + i][16:8]), 64'(exp_log[i][16:8]));
                else
                    chk($sformatf("midread_window%0d", i), 64'(win_log[w0 + i]), 64'(exp_log[i]));
            end
        end
        chk("midread_ack_drained", 64'(ack_q.size()), 64'd0);

        // Second request while one is still pending must be dropped.
        upd_q.push_back(pack6(8'h11, 8'h41, 8'h22, 8'h05, 8'h06, 8'h25));
        w0 = win_log.size();
        a0 = ack_cnt;
        wait_busy(1'b1, 300, "dup_wait_busy");
        wr_addr_i = 8'h10; wr_data_i = 8'h55; wr_req_i = 1'b1;
        ack_q.push_back(16'h1055);
        tick();
        wr_req_i = 1'b0;
        repeat (2) tick();
        wr_addr_i = 8'h11; wr_data_i = 8'h66; wr_req_i = 1'b1;
        tick();
        wr_req_i = 1'b0;
        wait_update(4000, "dup_update", n);
        chk("dup_ack_count", 64'(ack_cnt - a0), 64'd1);
        chk("dup_ack_drained", 64'(ack_q.size()), 64'd0);
        if (win_log.size() >= w0 + 3) begin
            chk("dup_window0", 64'(win_log[w0][16:8]), 64'({1'b1, 8'h21}));
            chk("dup_window1", 64'(win_log[w0 + 1]), 64'({1'b0, 8'h10, 8'h55}));
            chk("dup_window2", 64'(win_log[w0 + 2][16:8]), 64'({1'b1, 8'h22}));
        end else begin
            flag("dup_windows", $sformatf("only %0d windows", win_log.size() - w0));
        end

        // refresh_en dropped mid-read: window completes, then block idles.
        upd_q.push_back(pack6(8'h11, 8'h41, 8'h22, 8'h05, 8'h06, 8'h25));
        wait_busy(1'b1, 300, "refresh_wait_busy");
        repeat (20) tick();
        refresh_en_i = 1'b0;
        wait_busy(1'b0, 300, "refresh_wait_done");
        bc = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy_o) bc++;
        end
        chk("refresh_off_idle_busy_cycles", 64'(bc), 64'd0);
        refresh_en_i = 1'b1;
        wait_busy(1'b1, 10, "refresh_resume");
        chk("refresh_resume_address", 64'(address_o), 64'h22);
        chk("refresh_resume_indicador", 64'(indicador_maquina_o), 64'h1);
        wait_update(2000, "refresh_update", n);

        // Reset asserted at cnt=100 of a write window.
        refresh_en_i = 1'b0;
        a0 = ack_cnt;
        wr_addr_i = 8'h24; wr_data_i = 8'h31; wr_req_i = 1'b1;
        tick();
        wr_req_i = 1'b0;
        wait_busy(1'b1, 20, "reset_wr_wait_busy");
        chk("reset_wr_window_address", 64'(address_o), 64'h24);
        chk("reset_wr_window_indicador", 64'(indicador_maquina_o), 64'h0);
        repeat (100) tick();
        #3 reset_i = 1'b1;
        #1;
        check_reset_values("async_reset");
        repeat (2) tick();
        #2 reset_i = 1'b0;
        w0 = win_log.size();
        repeat (400) tick();
        chk("reset_no_wr_ack", 64'(ack_cnt - a0), 64'd0);
        chk("reset_write_discarded", 64'(win_log.size() - w0), 64'd0);
        chk("reset_fields_cleared", 64'(fields), 64'h0);

        chk("updates_drained", 64'(upd_q.size()), 64'd0);
        chk("acks_drained", 64'(ack_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
